nes_ram_arbiter: RTL and testbench
==================================

Name: nes_ram_arbiter

Overview:
- Shares one synchronous single-port work/cartridge RAM between two requesters: the NES core (port N) and the Nios host loader (port H, Avalon-MM slave with waitrequest).
- The NES core has fixed priority. A starvation guard gives the host one slot after it has been blocked for STARVE_LIMIT cycles.
- Sits between the NES core bus, the Nios Avalon fabric and the RAM macro. It replaces the host polling simple PIO status bits for RAM access.

Parameters:
- AW, 16, RAM address width.
- DW, 8, RAM data width.
- RD_LAT, 1, RAM read latency in cycles, from address to ram_rdata (legal 1..4).
- STARVE_LIMIT, 8, consecutive blocked host cycles before the host is forced a slot (legal 1..255).

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset
- nes_req  in  1  NES access request; held while nes_stall=1
- nes_we  in  1  1=write, 0=read
- nes_addr  in  AW  NES address
- nes_wdata  in  DW  NES write data
- nes_stall  out  1  request not granted this cycle; NES must hold its request
- nes_rdata  out  DW  NES read data
- nes_rvalid  out  1  nes_rdata valid, one-cycle pulse
- host_read  in  1  Avalon read
- host_write  in  1  Avalon write
- host_address  in  AW  Avalon address
- host_writedata  in  DW  Avalon write data
- host_waitrequest  out  1  Avalon waitrequest
- host_readdata  out  DW  Avalon read data
- host_readdatavalid  out  1  Avalon readdatavalid
- ram_addr  out  AW  RAM address
- ram_we  out  1  RAM write enable
- ram_wdata  out  DW  RAM write data
- ram_rdata  in  DW  RAM read data, valid RD_LAT cycles after address

Behaviour:
- Reset: reset_n is asynchronous, active-low; clock is clk. On reset:
  - all registered state clears: starve counter 0, host FSM H_IDLE, tag pipeline empty;
  - nes_rvalid=0, host_readdatavalid=0, nes_rdata=0, host_readdata=0.
- Arbitration, combinational each cycle:
  - host_pend = (host_read|host_write) & state==H_IDLE.
  - grant_h = host_pend & (~nes_req | force).
  - grant_n = nes_req & ~grant_h.
  - force = (starve_cnt >= STARVE_LIMIT).
  - nes_stall = nes_req & grant_h.
  - host_waitrequest = ~grant_h. It is also 1 whenever the FSM is not H_IDLE. With no host request it is 1, which is Avalon-legal.
- RAM drive (combinational):
  - grant_n: ram_addr/ram_we/ram_wdata come from the nes_* ports.
  - grant_h: they come from the host_* ports.
  - Neither granted: ram_we=0 and ram_addr holds its last granted value (registered shadow).
- Starve counter (8-bit, saturating at STARVE_LIMIT):
  - Increments when host_pend & ~grant_h.
  - Clears on grant_h or when ~host_pend.
- Host FSM:
  - H_IDLE: a granted read moves to H_RD_PEND. A granted write completes in the same cycle and stays in H_IDLE.
  - H_RD_PEND: waitrequest=1, so at most one host read is outstanding. Returns to H_IDLE in the cycle host_readdatavalid pulses.
- Read return: an RD_LAT-deep shift pipeline carries {valid, owner}. It is loaded on any granted read.
  - At the pipeline output: owner=N gives nes_rvalid=1 and nes_rdata=ram_rdata, registered.
  - Owner=H gives host_readdatavalid=1 and host_readdata=ram_rdata.
  - Total latency from grant cycle to rvalid is RD_LAT+1 cycles. The return path is registered.
  - Returns are in grant order. N and H returns never coincide, because only one grant happens per cycle.
- Simultaneous events:
  - A NES and host request in the same cycle goes to the NES unless force=1.
  - A forced host slot stalls the NES for exactly one cycle; the counter then clears.
  - host_read and host_write asserted together is treated as a read, with the write ignored. This is illegal on Avalon and is flagged by an assertion in simulation.
- Read-after-write to the same address in back-to-back cycles follows the RAM macro's behaviour; no forwarding.
- Reset mid-read flushes the pipeline; no rvalid is produced for in-flight reads.

Test Plan:
1. NES only: nes_req=1 read at addr 0x0123 with RAM preloaded 0xA5, RD_LAT=1 -> nes_stall=0; nes_rvalid pulses 2 cycles later with nes_rdata=0xA5.
2. Host write then read at idle NES: write 0x0200=0x3C, then read 0x0200 -> waitrequest=0 in each grant cycle; host_readdatavalid after 2 cycles with 0x3C; waitrequest=1 during H_RD_PEND.
3. Contention, STARVE_LIMIT=8: nes_req held continuously, host read pending -> host blocked 8 cycles; on cycle 9 grant_h=1 and nes_stall=1 for exactly 1 cycle; the NES is granted again the next cycle.
4. Interleaved returns, RD_LAT=3: NES read 0x0010 (0x11), forced host read 0x0020 (0x22), NES read 0x0030 (0x33) -> rvalids in grant order on the correct ports with the correct data; never both in one cycle.
5. Reset mid-operation: assert reset_n=0 one cycle after a host read grant -> no host_readdatavalid; FSM returns to H_IDLE; outputs at reset values; the next read works normally.
6. Idle: no requests for 20 cycles -> ram_we=0 throughout; ram_addr stable at its last value; no rvalid pulses.

Source files
------------

// File: rtl/nes_ram_arbiter.sv
// nes_ram_arbiter: shares one single-port RAM between the NES core and the Nios host
// Fixed NES priority; a starvation guard forces one host slot after STARVE_LIMIT blocked cycles.
module nes_ram_arbiter #(
    parameter int AW           = 16,
    parameter int DW           = 8,
    parameter int RD_LAT       = 1,
    parameter int STARVE_LIMIT = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          nes_req_i,
    input  logic          nes_we_i,
    input  logic [AW-1:0] nes_addr_i,
    input  logic [DW-1:0] nes_wdata_i,
    output logic          nes_stall_o,
    output logic [DW-1:0] nes_rdata_o,
    output logic          nes_rvalid_o,
    input  logic          host_read_i,
    input  logic          host_write_i,
    input  logic [AW-1:0] host_address_i,
    input  logic [DW-1:0] host_writedata_i,
    output logic          host_waitrequest_o,
    output logic [DW-1:0] host_readdata_o,
    output logic          host_readdatavalid_o,
    output logic [AW-1:0] ram_addr_o,
    output logic          ram_we_o,
    output logic [DW-1:0] ram_wdata_o,
    input  logic [DW-1:0] ram_rdata_i
);
    typedef enum logic {H_IDLE, H_RD_PEND} hstate_e;

    hstate_e         state_q;
    logic [7:0]      starve_q, starve_d;
    logic [AW-1:0]   addr_q;
    logic [RD_LAT-1:0] pv_q, pv_d, po_q, po_d;
    logic            nes_rvalid_q, host_rdv_q;
    logic [DW-1:0]   nes_rdata_q, host_rdata_q;
    logic            host_pend, force_h, grant_h, grant_n, rd_grant, out_n, out_h;

    assign host_pend = (host_read_i | host_write_i) & (state_q == H_IDLE);
    assign force_h   = starve_q >= 8'(STARVE_LIMIT);
    assign grant_h   = host_pend & (~nes_req_i | force_h);
    assign grant_n   = nes_req_i & ~grant_h;
    assign rd_grant  = (grant_n & ~nes_we_i) | (grant_h & host_read_i);

    assign nes_stall_o        = nes_req_i & grant_h;
    assign host_waitrequest_o = ~grant_h;

    // A simultaneous read+write from the host is served as a read only
    assign ram_addr_o  = grant_n ? nes_addr_i : grant_h ? host_address_i : addr_q;
    assign ram_we_o    = grant_n ? nes_we_i : (grant_h & host_write_i & ~host_read_i);
    assign ram_wdata_o = grant_h ? host_writedata_i : nes_wdata_i;

    assign starve_d = (~host_pend | grant_h) ? 8'd0 : force_h ? starve_q : starve_q + 8'd1;

    // {valid, owner} shift pipeline; owner 1 = host
    assign pv_d  = (pv_q << 1) | RD_LAT'(rd_grant);
    assign po_d  = (po_q << 1) | RD_LAT'(grant_h);
    assign out_n = pv_q[RD_LAT-1] & ~po_q[RD_LAT-1];
    assign out_h = pv_q[RD_LAT-1] & po_q[RD_LAT-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= H_IDLE;
            starve_q     <= '0;
            addr_q       <= '0;
            pv_q         <= '0;
            po_q         <= '0;
            nes_rvalid_q <= 1'b0;
            host_rdv_q   <= 1'b0;
            nes_rdata_q  <= '0;
            host_rdata_q <= '0;
        end else begin
            starve_q     <= starve_d;
            pv_q         <= pv_d;
            po_q         <= po_d;
            nes_rvalid_q <= out_n;
            host_rdv_q   <= out_h;
            if (grant_n | grant_h) addr_q <= ram_addr_o;
            if (out_n) nes_rdata_q <= ram_rdata_i;
            if (out_h) host_rdata_q <= ram_rdata_i;
            case (state_q)
                H_IDLE:    if (grant_h & host_read_i) state_q <= H_RD_PEND;
                H_RD_PEND: if (out_h) state_q <= H_IDLE;
                default:   state_q <= H_IDLE;
            endcase
        end
    end

    assign nes_rvalid_o         = nes_rvalid_q;
    assign nes_rdata_o          = nes_rdata_q;
    assign host_readdatavalid_o = host_rdv_q;
    assign host_readdata_o      = host_rdata_q;

    // Avalon forbids read and write in the same cycle
    host_rw_exclusive: assert property (@(posedge clk) disable iff (!reset_n)
        !(host_read_i && host_write_i));
endmodule

// File: tb/tb_nes_ram_arbiter.sv
// tb_nes_ram_arbiter: directed and random checks of nes_ram_arbiter against a transaction-level model
// The model tracks memory contents, outstanding returns by due cycle, host busy window and blocked count.
module tb_nes_ram_arbiter;
    localparam int AW = 16;
    localparam int DW = 8;
    localparam int RD_LAT = 3;
    localparam int SL = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          nes_req, nes_we, nes_stall, nes_rvalid;
    logic [AW-1:0] nes_addr;
    logic [DW-1:0] nes_wdata, nes_rdata;
    logic          host_read, host_write, host_waitrequest, host_readdatavalid;
    logic [AW-1:0] host_address;
    logic [DW-1:0] host_writedata, host_readdata;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_wdata, ram_rdata;

    nes_ram_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .reset_n(reset_n),
        .nes_req_i(nes_req), .nes_we_i(nes_we), .nes_addr_i(nes_addr), .nes_wdata_i(nes_wdata),
        .nes_stall_o(nes_stall), .nes_rdata_o(nes_rdata), .nes_rvalid_o(nes_rvalid),
        .host_read_i(host_read), .host_write_i(host_write), .host_address_i(host_address),
        .host_writedata_i(host_writedata), .host_waitrequest_o(host_waitrequest),
        .host_readdata_o(host_readdata), .host_readdatavalid_o(host_readdatavalid),
        .ram_addr_o(ram_addr), .ram_we_o(ram_we), .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata)
    );

    always #5 clk = ~clk;

    // RAM macro: synchronous, read data RD_LAT cycles after the address, plus a preload port
    logic          pl_en = 1'b0;
    logic [AW-1:0] pl_a;
    logic [DW-1:0] pl_d;
    logic [DW-1:0] mem [0:65535];
    logic [DW-1:0] rp [RD_LAT];
    always @(posedge clk) begin
        if (pl_en) mem[pl_a] <= pl_d;
        else if (ram_we) mem[ram_addr] <= ram_wdata;
        rp[0] <= mem[ram_addr];
        for (int i = 1; i < RD_LAT; i++) rp[i] <= rp[i-1];
    end
    assign ram_rdata = rp[RD_LAT-1];

    typedef struct { int due; bit host; logic [DW-1:0] d; } ret_t;
    ret_t          rq[$];
    logic [DW-1:0] mm [0:65535];
    int            cyc = 0, starve = 0, h_free_at = 0;
    logic [AW-1:0] last_addr = '0;
    int            n_assert = 0, n_fail = 0;
    bit            obs_hg, obs_stall;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d: observed %h expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic got, input logic exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d: observed %b expected %b", tag, cyc, got, exp);
        end
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pl_en = 1'b1; pl_a = a; pl_d = d; mm[a] = d;
        @(posedge clk); @(negedge clk);
        pl_en = 1'b0;
    endtask

    // One clock cycle: check outputs against the model, then advance the model at the edge
    task automatic step();
        logic          hw, hg, ng, ewe;
        logic [AW-1:0] ea;
        ret_t          r;
        bit            nv, hv;
        logic [DW-1:0] rd;
        #1;
        hw  = (host_read || host_write) && cyc >= h_free_at;
        hg  = hw && (!nes_req || starve >= SL);
        ng  = nes_req && !hg;
        ea  = ng ? nes_addr : hg ? host_address : last_addr;
        ewe = ng ? nes_we : (hg && host_write && !host_read);
        chkb("nes_stall", nes_stall, nes_req && hg);
        chkb("waitrequest", host_waitrequest, !hg);
        chk("ram_addr", ram_addr, ea);
        chkb("ram_we", ram_we, ewe);
        if (ewe) chk("ram_wdata", 16'(ram_wdata), 16'(hg ? host_writedata : nes_wdata));
        nv = 0; hv = 0; rd = '0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            r = rq.pop_front(); nv = !r.host; hv = r.host; rd = r.d;
        end
        chkb("nes_rvalid", nes_rvalid, nv);
        chkb("host_rdv", host_readdatavalid, hv);
        chkb("both_rvalid", nes_rvalid && host_readdatavalid, 1'b0);
        if (nv) chk("nes_rdata", 16'(nes_rdata), 16'(rd));
        if (hv) chk("host_rdata", 16'(host_readdata), 16'(rd));
        obs_hg = !host_waitrequest; obs_stall = nes_stall;
        @(posedge clk);
        if (ng && nes_we) mm[nes_addr] = nes_wdata;
        if (ng && !nes_we) rq.push_back('{cyc + RD_LAT + 1, 1'b0, mm[nes_addr]});
        if (hg && host_read) begin
            rq.push_back('{cyc + RD_LAT + 1, 1'b1, mm[host_address]});
            h_free_at = cyc + RD_LAT + 1;
        end
        if (hg && !host_read) mm[host_address] = host_writedata;
        if (ng || hg) last_addr = ea;
        starve = (hw && !hg) ? ((starve < SL) ? starve + 1 : SL) : 0;
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        int k, nblk;
        reset_n = 1'b0;
        nes_req = 0; nes_we = 0; nes_addr = '0; nes_wdata = '0;
        host_read = 0; host_write = 0; host_address = '0; host_writedata = '0;
        for (int a = 0; a < 256; a++) preload(16'(a), 8'($urandom));
        preload(16'h0123, 8'hA5);
        preload(16'h0010, 8'h11);
        preload(16'h0020, 8'h22);
        preload(16'h0030, 8'h33);
        #1;
        chkb("rst_nes_rvalid", nes_rvalid, 1'b0);
        chkb("rst_host_rdv", host_readdatavalid, 1'b0);
        chk("rst_nes_rdata", 16'(nes_rdata), 16'h0);
        chk("rst_host_rdata", 16'(host_readdata), 16'h0);
        chkb("rst_waitreq", host_waitrequest, 1'b1);
        @(negedge clk);
        reset_n = 1'b1;

        // NES-only read of a preloaded location
        nes_req = 1; nes_we = 0; nes_addr = 16'h0123;
        step();
        chkb("t1_no_stall", obs_stall, 1'b0);
        nes_req = 0;
        repeat (RD_LAT + 2) step();

        // Host write then read-back with the NES idle
        host_write = 1; host_address = 16'h0200; host_writedata = 8'h3C;
        step();
        chkb("t2_wr_grant", obs_hg, 1'b1);
        host_write = 0; host_read = 1;
        step();
        chkb("t2_rd_grant", obs_hg, 1'b1);
        host_read = 0;
        repeat (RD_LAT + 2) step();

        // Contention: NES reads continuously, host read waits for the forced slot
        nes_req = 1; nes_we = 0; nes_addr = 16'h0010;
        host_read = 1; host_address = 16'h0020;
        nblk = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (obs_hg) break;
            nblk++;
        end
        chk("t3_blocked_cycles", 16'(nblk), 16'(SL));
        chkb("t3_forced_stall", obs_stall, 1'b1);
        host_read = 0;
        step();
        chkb("t3_nes_regrant", obs_stall, 1'b0);
        nes_addr = 16'h0030;
        step();
        nes_req = 0;
        repeat (RD_LAT + 3) step();

        // Reset one cycle after a host read grant flushes the return
        host_read = 1; host_address = 16'h0021;
        step();
        host_read = 0;
        step();
        reset_n = 1'b0;
        #1;
        chkb("t5_waitreq", host_waitrequest, 1'b1);
        chkb("t5_ram_we", ram_we, 1'b0);
        chk("t5_ram_addr", ram_addr, 16'h0);
        chk("t5_host_rdata", 16'(host_readdata), 16'h0);
        chk("t5_nes_rdata", 16'(nes_rdata), 16'h0);
        repeat (RD_LAT + 2) begin
            @(posedge clk); @(negedge clk);
            chkb("t5_no_rdv", host_readdatavalid, 1'b0);
            chkb("t5_no_nrv", nes_rvalid, 1'b0);
        end
        reset_n = 1'b1;
        rq.delete(); h_free_at = 0; starve = 0; last_addr = '0;
        repeat (RD_LAT + 2) step();
        host_read = 1; host_address = 16'h0022;
        step();
        chkb("t5_post_grant", obs_hg, 1'b1);
        host_read = 0;
        repeat (RD_LAT + 2) step();

        // Idle: no requests, RAM address parked, nothing returned
        nes_req = 1; nes_we = 1; nes_addr = 16'h0055; nes_wdata = 8'h5A;
        step();
        nes_req = 0; nes_we = 0;
        repeat (20) step();

        // Random traffic with protocol-correct holding on stall / waitrequest
        obs_hg = 0; obs_stall = 0;
        for (int i = 0; i < 600; i++) begin
            if (!(nes_req && obs_stall)) begin
                nes_req   = $urandom_range(0, 99) < 60;
                nes_we    = $urandom_range(0, 3) == 0;
                nes_addr  = 16'($urandom_range(0, 255));
                nes_wdata = 8'($urandom);
            end
            if (!((host_read || host_write) && !obs_hg)) begin
                k = $urandom_range(0, 9);
                host_read      = k < 3;
                host_write     = k >= 3 && k < 5;
                host_address   = 16'($urandom_range(0, 255));
                host_writedata = 8'($urandom);
            end
            step();
        end
        nes_req = 0; host_read = 0; host_write = 0;
        repeat (RD_LAT + 3) step();
        chk("queue_drained", 16'(rq.size()), 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
